opc_ext_bus_bridge: RTL
=======================

# opc_ext_bus_bridge

Bus responder that sits between the OPC CPU core's parallel memory bus and the chip's pins, servicing each CPU read or write as a multi-phase external transaction. It time-multiplexes the 11-bit address and rnw onto the 8 dedicated outputs, moves data over the 8 bidirectional IOs, honours an external wait input with a bounded timeout, and returns read data plus a one-cycle ready to the CPU. The CPU stalls on `cpu_req && !cpu_ready`.

## Interface
- `WAIT_MAX`, 15: maximum wait-state cycles in DATA before forced completion (1..15).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU access request; held with addr/rnw/wdata until `cpu_ready`.
- `cpu_addr`  in  11  access address.
- `cpu_rnw`  in  1  1 = read, 0 = write.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data; valid while `cpu_ready`=1, held until next read completes.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  sticky timeout flag.
- `pin_out`  out  8  to `uo_out`: [7:6] phase code, [5:0] payload.
- `pin_wait`  in  1  from `ui_in[0]`: external wait, active high.
- `pin_data_in`  in  8  from `uio_in`.
- `pin_data_out`  out  8  to `uio_out`.
- `pin_data_oe`  out  8  to `uio_oe`.

## Operation
- States: IDLE, ADDR_LO, ADDR_HI, DATA, DONE.
- IDLE: if `cpu_req`, latch addr/rnw/wdata at the edge and go to ADDR_LO; else stay.
- ADDR_LO -> ADDR_HI -> DATA unconditionally.
- DATA: if `pin_wait`=0 or wait counter = `WAIT_MAX`, go to DONE; else increment counter and stay.
- DONE -> IDLE unconditionally (no new acceptance in DONE, so a still-high `cpu_req` never double-issues).
- `pin_out` per state: IDLE 8'h00; ADDR_LO {2'b01, addr[5:0]}; ADDR_HI {2'b10, rnw, addr[10:6]}; DATA and DONE {2'b11, 6'b0}.
- Write: `pin_data_oe`=8'hFF and `pin_data_out`=latched wdata in DATA only; elsewhere oe=0, out=0.
- Read: `pin_data_oe`=0 always; `pin_data_in` captured into `cpu_rdata` on the DATA->DONE edge when `pin_wait`=0.
- Timeout (counter hits `WAIT_MAX` with `pin_wait`=1): complete anyway; read data = 8'hFF; write is treated as done; `bus_err` set, cleared only by reset.
- Wait counter: 4 bits, cleared on entry to DATA; never wraps.
- `cpu_ready`=1 exactly in DONE.
- All pin outputs derive from the state register and latched registers only, never combinationally from CPU inputs.

## Timing
- Reset (async): state IDLE, `pin_out`=0, `pin_data_out`=0, `pin_data_oe`=0, `cpu_rdata`=0, `cpu_ready`=0, `bus_err`=0, counter 0.
- Request seen in IDLE at edge E0: ADDR_LO E0..E1, ADDR_HI E1..E2, DATA from E2 (min 1 cycle), DONE 1 cycle.
- Zero-wait access: `cpu_ready` in the 4th cycle after acceptance. Minimum of 5 cycles per access including IDLE.
- Each wait cycle adds 1 cycle. Worst case is `WAIT_MAX` extra cycles.
- Reset asserted mid-transaction: pins return to idle immediately, with no ready pulse and no `bus_err` change beyond clearing. The CPU is reset by the same `rst_n`.

## Structure
- Shared package `opc_bus_pkg`: state enum, phase codes (IDLE 2'b00, ALO 2'b01, AHI 2'b10, DAT 2'b11), `WAIT_MAX` default, timeout read value 8'hFF.
- Single module with no sub-module. The wait counter is inline.

## Test plan
- Write 0x3C to 0x5A3, `pin_wait`=0: `pin_out` sequence 0x63, 0x96, 0xC0 (oe=FF, out=3C), `cpu_ready` pulse, then 0x00.
- Read 0x7FF with `pin_wait` high for 2 DATA cycles, `pin_data_in`=0x81: `pin_out` 0x7F, 0xBF, 0xC0×3, oe=0, `cpu_rdata`=0x81 with `cpu_ready` on the 6th cycle after acceptance.
- `pin_wait` stuck high: after 15 wait cycles, `cpu_ready` pulses, `cpu_rdata`=0xFF, `bus_err`=1 and stays 1 through later good accesses.
- `cpu_req` held high through DONE: exactly one ready per access, and the next ADDR_LO starts only after one IDLE cycle.
- `rst_n` pulsed low during DATA of a write: `pin_data_oe`=0, `pin_out`=0 immediately, no `cpu_ready`, clean access after release.

Source files
------------

// File: rtl/opc_bus_pkg.sv
// rtl/opc_bus_pkg.sv - shared state, phase codes and constants for the OPC external bus bridge
package opc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_DATA,
    ST_DONE
  } bus_state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_ALO  = 2'b01;
  localparam logic [1:0] PH_AHI  = 2'b10;
  localparam logic [1:0] PH_DAT  = 2'b11;

  localparam int         WAIT_MAX_DEFAULT = 15;
  localparam logic [7:0] TIMEOUT_RDATA    = 8'hFF;

endpackage

// File: rtl/opc_ext_bus_bridge.sv
// rtl/opc_ext_bus_bridge.sv - multi-phase external bus responder for the OPC CPU memory bus
module opc_ext_bus_bridge
  import opc_bus_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [10:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        bus_err,
  output logic [7:0]  pin_out,
  input  logic        pin_wait,
  input  logic [7:0]  pin_data_in,
  output logic [7:0]  pin_data_out,
  output logic [7:0]  pin_data_oe
);

  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_MAX);

  bus_state_t  state_q, state_d;
  logic [10:0] addr_q;
  logic        rnw_q;
  logic [7:0]  wdata_q;
  logic [3:0]  wait_cnt_q;
  logic [7:0]  rdata_q;
  logic        bus_err_q;
  logic        at_limit;
  logic        data_end;
  logic        timeout;

  assign at_limit = (wait_cnt_q == WAIT_LIMIT);
  assign data_end = !pin_wait || at_limit;
  assign timeout  = pin_wait && at_limit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cpu_req) state_d = ST_ADDR_LO;
      ST_ADDR_LO: state_d = ST_ADDR_HI;
      ST_ADDR_HI: state_d = ST_DATA;
      ST_DATA:    if (data_end) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        rnw_q   <= cpu_rnw;
        wdata_q <= cpu_wdata;
      end
      // counter saturates at the limit because DATA exits before it could increment past it
      if (state_q == ST_ADDR_HI) begin
        wait_cnt_q <= '0;
      end else if (state_q == ST_DATA && !data_end) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
      if (state_q == ST_DATA && data_end) begin
        if (timeout) begin
          bus_err_q <= 1'b1;
          if (rnw_q) rdata_q <= TIMEOUT_RDATA;
        end else if (rnw_q) begin
          rdata_q <= pin_data_in;
        end
      end
    end
  end

  // pins decode only registered state so CPU input glitches never reach the package
  always_comb begin
    pin_out      = {PH_IDLE, 6'b0};
    pin_data_out = '0;
    pin_data_oe  = '0;
    cpu_ready    = 1'b0;
    case (state_q)
      ST_ADDR_LO: pin_out = {PH_ALO, addr_q[5:0]};
      ST_ADDR_HI: pin_out = {PH_AHI, rnw_q, addr_q[10:6]};
      ST_DATA: begin
        pin_out = {PH_DAT, 6'b0};
        if (!rnw_q) begin
          pin_data_oe  = 8'hFF;
          pin_data_out = wdata_q;
        end
      end
      ST_DONE: begin
        pin_out   = {PH_DAT, 6'b0};
        cpu_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign bus_err   = bus_err_q;

endmodule
